// File: rtl/poly_synth_dac.sv
// poly_synth_dac: polyphonic square-wave synthesiser with a serial DAC driver.
// NUM_KEYS voices each advance a phase accumulator at every sample tick.
// The accumulator MSB is the voice's square wave. The active voices are
// summed into a DAC_W-bit sample, and that sample is sent as a 32-bit SPI frame.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   keys               key pressed = 1, sampled at sample ticks
//   tune_we/sel/inc    write strobe, voice index and new phase increment
//   dac_cs             DAC chip select, active low
//   spi_sck, spi_mosi  SPI clock (idle low) and data (MSB first)
//   dac_clr            DAC clear, active low, held after reset release
//   busy               frame in flight (dac_cs low)
//   overrun            sticky, a sample tick arrived while a frame was busy
module poly_synth_dac #(
  parameter int unsigned        NUM_KEYS    = 4,
  parameter int unsigned        PHASE_W     = 24,
  parameter int unsigned        DAC_W       = 12,
  parameter int unsigned        SAMPLE_DIV  = 1250,
  parameter int unsigned        SCK_DIV     = 4,
  parameter int unsigned        CLR_CYCLES  = 16,
  parameter logic [3:0]         DAC_CMD     = 4'b0011,
  parameter logic [3:0]         DAC_ADDR    = 4'b0000,
  parameter logic [PHASE_W-1:0] DEFAULT_INC = PHASE_W'(5767),
  localparam int unsigned       SEL_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                tune_we,
  input  logic [SEL_W-1:0]    tune_sel,
  input  logic [PHASE_W-1:0]  tune_inc,
  output logic                dac_cs,
  output logic                spi_sck,
  output logic                spi_mosi,
  output logic                dac_clr,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned POP_W = $clog2(NUM_KEYS + 1);
  localparam int unsigned STEP  = (2 ** DAC_W - 1) / NUM_KEYS;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t               state, state_nxt;
  logic [CLR_W-1:0]     clr_cnt;
  logic [CNT_W-1:0]     cnt;
  logic                 tick, tick_d, start;
  logic [PHASE_W-1:0]   acc  [NUM_KEYS];
  logic [PHASE_W-1:0]   tune [NUM_KEYS];
  logic [NUM_KEYS-1:0]  keys_q;
  logic [POP_W-1:0]     pop;
  logic [DAC_W-1:0]     sample;
  logic [11:0]          samp12;
  logic [31:0]          frame_word;
  logic [31:0]          shreg;
  logic [DIV_W-1:0]     div_cnt;
  logic                 div_last;
  logic [4:0]           bit_cnt;
  logic                 sck_q;

  assign tick     = (state != S_INIT) && (cnt == CNT_W'(SAMPLE_DIV - 1));
  assign div_last = (div_cnt == DIV_W'(SCK_DIV - 1));

  if (DAC_W >= 12) begin : g_wide
    assign samp12 = sample[DAC_W-1 -: 12];
  end else begin : g_narrow
    assign samp12 = {sample, {(12 - DAC_W){1'b0}}};
  end

  assign frame_word = {8'h00, DAC_CMD, DAC_ADDR, samp12, 4'h0};

  // keys_q holds the key state seen at the last tick, so a release on a tick
  // removes the voice from that very sample.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      pop = pop + POP_W'(keys_q[i] & acc[i][PHASE_W-1]);
    end
  end

  // Tick counter, oscillators, mixer and the start pulse two cycles after a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tick_d <= 1'b0;
      start  <= 1'b0;
      keys_q <= '0;
      sample <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        acc[i]  <= '0;
        tune[i] <= DEFAULT_INC << i;
      end
    end else begin
      if (state == S_INIT || tick) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      tick_d <= tick;
      start  <= tick_d;
      if (tick) begin
        keys_q <= keys;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
          acc[i] <= keys[i] ? acc[i] + tune[i] : '0;
        end
      end
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (tune_we && tune_sel == SEL_W'(i)) tune[i] <= tune_inc;
      end
      if (tick_d) sample <= DAC_W'(32'(pop) * STEP);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = S_IDLE;
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: if (div_last) state_nxt = S_SHIFT;
      S_SHIFT: if (div_last && !sck_q && bit_cnt == 5'd0) state_nxt = S_HOLD;
      S_HOLD:  if (div_last) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    dac_cs   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    dac_clr  = 1'b1;
    unique case (state)
      S_INIT:  dac_clr = 1'b0;
      S_SETUP: begin
        dac_cs   = 1'b0;
        spi_mosi = shreg[31];
      end
      S_SHIFT: begin
        dac_cs   = 1'b0;
        spi_sck  = sck_q;
        spi_mosi = shreg[31];
      end
      S_HOLD:  dac_cs = 1'b0;
      default: ;
    endcase
    busy = ~dac_cs;
  end

  // Frame datapath: each bit is one high half-period followed by one low
  // half-period. The shift happens on the falling edge, so mosi is stable
  // across every high window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck_q   <= 1'b0;
      shreg   <= '0;
      overrun <= 1'b0;
    end else begin
      if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
      if (state == S_SETUP || state == S_SHIFT || state == S_HOLD)
        div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;
      if (start) begin
        if (state == S_IDLE) shreg   <= frame_word;
        else                 overrun <= 1'b1;
      end
      if (state == S_SETUP && div_last) begin
        sck_q   <= 1'b1;
        bit_cnt <= 5'd31;
      end
      if (state == S_SHIFT && div_last) begin
        if (sck_q) begin
          sck_q <= 1'b0;
          shreg <= {shreg[30:0], 1'b0};
        end else if (bit_cnt != 5'd0) begin
          sck_q   <= 1'b1;
          bit_cnt <= bit_cnt - 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_synth_dac.sv
// Directed bench for poly_synth_dac. There are three instances:
//   dut_a  default parameters (timing, single voice, chord, restart, tune-on-tick, mid-run reset)
//   dut_k  NUM_KEYS=3, SAMPLE_DIV=400 (out-of-range tune_sel, STEP=1365)
//   dut_o  SAMPLE_DIV=100 (overrun)
module tb_poly_synth_dac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a = 1'b1, rst_k = 1'b1, rst_o = 1'b1;
  logic [3:0]  keys_a = '0, keys_o = '0;
  logic [2:0]  keys_k = '0;
  logic        tune_we = 1'b0;
  logic [1:0]  tune_sel = '0;
  logic [23:0] tune_inc = '0;

  logic cs_a, sck_a, mosi_a, clr_a, busy_a, ovr_a;
  logic cs_k, sck_k, mosi_k, clr_k, busy_k, ovr_k;
  logic cs_o, sck_o, mosi_o, clr_o, busy_o, ovr_o;

  poly_synth_dac dut_a (
    .clk(clk), .rst(rst_a), .keys(keys_a), .tune_we(tune_we), .tune_sel(tune_sel),
    .tune_inc(tune_inc), .dac_cs(cs_a), .spi_sck(sck_a), .spi_mosi(mosi_a),
    .dac_clr(clr_a), .busy(busy_a), .overrun(ovr_a)
  );

  poly_synth_dac #(.NUM_KEYS(3), .SAMPLE_DIV(400)) dut_k (
    .clk(clk), .rst(rst_k), .keys(keys_k), .tune_we(tune_we), .tune_sel(tune_sel),
    .tune_inc(tune_inc), .dac_cs(cs_k), .spi_sck(sck_k), .spi_mosi(mosi_k),
    .dac_clr(clr_k), .busy(busy_k), .overrun(ovr_k)
  );

  poly_synth_dac #(.SAMPLE_DIV(100)) dut_o (
    .clk(clk), .rst(rst_o), .keys(keys_o), .tune_we(tune_we), .tune_sel(tune_sel),
    .tune_inc(tune_inc), .dac_cs(cs_o), .spi_sck(sck_o), .spi_mosi(mosi_o),
    .dac_clr(clr_o), .busy(busy_o), .overrun(ovr_o)
  );

  logic [1:0] dsel = 2'd0;
  logic obs_cs, obs_sck, obs_mosi, obs_clr, obs_busy;
  assign obs_cs   = (dsel == 2'd0) ? cs_a   : (dsel == 2'd1) ? cs_k   : cs_o;
  assign obs_sck  = (dsel == 2'd0) ? sck_a  : (dsel == 2'd1) ? sck_k  : sck_o;
  assign obs_mosi = (dsel == 2'd0) ? mosi_a : (dsel == 2'd1) ? mosi_k : mosi_o;
  assign obs_clr  = (dsel == 2'd0) ? clr_a  : (dsel == 2'd1) ? clr_k  : clr_o;
  assign obs_busy = (dsel == 2'd0) ? busy_a : (dsel == 2'd1) ? busy_k : busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fw(input logic [11:0] s);
    return {8'h00, 4'h3, 4'h0, s, 4'h0};
  endfunction

  logic [31:0] f_word;
  int          f_fall, f_len, f_per, f_rises;
  logic        f_ok;

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic write_tune(input logic [1:0] sel, input logic [23:0] val);
    tune_sel = sel;
    tune_inc = val;
    tune_we  = 1'b1;
    @(posedge clk); #1;
    tune_we  = 1'b0;
  endtask

  // Samples one clk after each edge; a bit is taken on each sck rise.
  task automatic cap_frame();
    int   n;
    int   r1;
    logic prev_sck;
    logic cur;
    f_word = '0; f_fall = -1; f_len = 0; f_per = 0; f_rises = 0; f_ok = 1'b1;
    r1 = 0; cur = 1'b0; n = 0;
    while (obs_cs !== 1'b0 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (obs_cs !== 1'b0) begin
      check("cs_fall_timeout", {31'b0, obs_cs}, 32'd0);
      return;
    end
    f_fall   = cyc;
    prev_sck = obs_sck;
    while (obs_cs === 1'b0 && f_len < 400) begin
      f_len++;
      @(posedge clk); #1;
      if (obs_busy !== ~obs_cs) f_ok = 1'b0;
      if (obs_sck === 1'b1 && prev_sck === 1'b0) begin
        f_rises++;
        f_word = {f_word[30:0], obs_mosi};
        cur    = obs_mosi;
        if (f_rises == 1) r1 = cyc;
        if (f_rises == 2) f_per = cyc - r1;
      end else if (obs_sck === 1'b1 && obs_mosi !== cur) begin
        f_ok = 1'b0;
      end
      prev_sck = obs_sck;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] exp_word);
    cap_frame();
    if (f_fall < 0) return;
    check(tag, f_word, exp_word);
    check({tag, "_len"}, f_len, 32'd264);
    check({tag, "_bits"}, f_rises, 32'd32);
    check({tag, "_per"}, f_per, 32'd8);
    check({tag, "_stable"}, {31'b0, f_ok}, 32'd1);
  endtask

  task automatic measure_init(input int c0, input int exp_delay, input logic [31:0] exp_word);
    int n;
    int r;
    n = 0;
    while (obs_clr !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("clr_len", cyc - c0, 32'd16);
    r = cyc;
    expect_frame("first", exp_word);
    if (f_fall >= 0) check("first_cs", f_fall - r, exp_delay);
  endtask

  initial begin
    int c0;
    int r;
    int n;
    int prev_fall;

    // ---- dut_a: reset and INIT timing ----
    dsel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vals", {26'b0, cs_a, sck_a, mosi_a, clr_a, busy_a, ovr_a}, 32'b100000);
    c0 = cyc;
    rst_a = 1'b0;
    measure_init(c0, 1252, fw(12'd0));

    // ---- single voice ----
    write_tune(2'd0, 24'h800000);
    keys_a = 4'b0001;
    expect_frame("sv1", fw(12'd1023));
    expect_frame("sv2", fw(12'd0));
    expect_frame("sv3", fw(12'd1023));
    keys_a = 4'b0000;
    expect_frame("sv_off", fw(12'd0));

    // ---- full chord, then drop key 2 ----
    write_tune(2'd1, 24'h800000);
    write_tune(2'd2, 24'h800000);
    write_tune(2'd3, 24'h800000);
    keys_a = 4'b1111;
    expect_frame("chord1", fw(12'd4092));
    expect_frame("chord2", fw(12'd0));
    keys_a = 4'b1011;
    expect_frame("drop2", fw(12'd3069));

    // ---- release restarts a voice at phase 0 ----
    keys_a = 4'b0000;
    write_tune(2'd1, 24'h400000);
    expect_frame("rel_clear", fw(12'd0));
    keys_a = 4'b0010;
    expect_frame("hold1", fw(12'd0));
    expect_frame("hold2", fw(12'd1023));
    expect_frame("hold3", fw(12'd1023));
    keys_a = 4'b0000;
    expect_frame("released", fw(12'd0));
    keys_a = 4'b0010;
    expect_frame("repress1", fw(12'd0));
    expect_frame("repress2", fw(12'd1023));
    expect_frame("repress3", fw(12'd1023));

    // ---- tune write landing exactly on a tick edge ----
    keys_a = 4'b0001;
    write_tune(2'd0, 24'h400000);
    expect_frame("tt_a", fw(12'd0));
    // the next tick edge is 1248 edges after this dac_cs fall
    wait_until(f_fall + 1247);
    write_tune(2'd0, 24'h600000);
    expect_frame("tt_b", fw(12'd1023));
    expect_frame("tt_c", fw(12'd1023));
    expect_frame("tt_d", fw(12'd0));
    expect_frame("tt_e", fw(12'd1023));

    // ---- reset asserted in the middle of a frame ----
    keys_a = 4'b0000;
    wait_until(f_fall + 1250 + 5);
    check("pre_rst_sck", {31'b0, sck_a}, 32'd1);
    #2;
    rst_a = 1'b1;
    #1;
    check("midrst_vals", {26'b0, cs_a, sck_a, mosi_a, clr_a, busy_a, ovr_a}, 32'b100000);
    repeat (2) @(posedge clk);
    #1;
    c0 = cyc;
    rst_a = 1'b0;
    measure_init(c0, 1252, fw(12'd0));

    // ---- dut_k: three voices, out-of-range tune_sel ignored ----
    dsel = 2'd1;
    @(posedge clk); #1;
    c0 = cyc;
    rst_k = 1'b0;
    measure_init(c0, 402, fw(12'd0));
    write_tune(2'd0, 24'h800000);
    write_tune(2'd3, 24'h000000);
    keys_k = 3'b001;
    expect_frame("k3_1", fw(12'd1365));
    expect_frame("k3_2", fw(12'd0));
    expect_frame("k3_3", fw(12'd1365));

    // ---- dut_o: overrun with SAMPLE_DIV=100 ----
    dsel = 2'd2;
    @(posedge clk); #1;
    c0 = cyc;
    rst_o = 1'b0;
    n = 0;
    while (clr_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("o_clr_len", cyc - c0, 32'd16);
    r = cyc;
    wait_until(r + 150);
    check("ovr_pre", {31'b0, ovr_o}, 32'd0);
    check("ovr_busy", {31'b0, busy_o}, 32'd1);
    wait_until(r + 210);
    check("ovr_set", {31'b0, ovr_o}, 32'd1);
    n = 0;
    while (cs_o === 1'b0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    expect_frame("ovr_f2", fw(12'd0));
    if (f_fall >= 0) check("ovr_f2_start", f_fall - r, 32'd402);
    prev_fall = f_fall;
    expect_frame("ovr_f3", fw(12'd0));
    if (f_fall >= 0) check("ovr_gap", f_fall - prev_fall, 32'd300);
    check("ovr_sticky", {31'b0, ovr_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
